// File: rtl/chip8_pkg.sv
// Shared CHIP-8 bus widths, memory map and responder phase encoding.
// Used by the memory responder and the CPU.
package chip8_pkg;
  localparam int ADDR_W = 12;
  localparam int RAM_DEPTH = 1 << ADDR_W;
  localparam int FONT_LEN = 80;
  localparam logic [ADDR_W-1:0] LOAD_BASE = 12'h200;
  localparam logic [ADDR_W-1:0] FONT_BASE = 12'h000;

  typedef enum logic [1:0] {
    ST_FONT,
    ST_LOAD,
    ST_RUN
  } state_t;
endpackage

// File: rtl/chip8_mem_responder_if.sv
// CHIP-8 CPU byte bus: master = CPU, slave = memory responder.
// Reads are acknowledged with a one-cycle pulse; writes are single strobes.
interface chip8_mem_responder_if;
  import chip8_pkg::*;

  logic              mem_read;
  logic [ADDR_W-1:0] mem_read_idx;
  logic              mem_read_ack;
  logic [7:0]        mem_read_byte;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_write_idx;
  logic [7:0]        mem_write_byte;

  modport master (
    output mem_read, mem_read_idx,
    output mem_write, mem_write_idx, mem_write_byte,
    input  mem_read_ack, mem_read_byte
  );

  modport slave (
    input  mem_read, mem_read_idx,
    input  mem_write, mem_write_idx, mem_write_byte,
    output mem_read_ack, mem_read_byte
  );
endinterface

// File: rtl/chip8_font_rom.sv
// Standard CHIP-8 hex font: 16 glyphs x 5 rows, row index -> byte.
// Only instantiated when CHIP8_FONT_INIT_EN is defined.
module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] i_idx,
  output logic [7:0] o_row
);
  localparam logic [7:0] GLYPH [FONT_LEN] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  assign o_row = (int'(i_idx) < FONT_LEN) ? GLYPH[i_idx] : 8'h00;
endmodule

// File: rtl/chip8_mem_responder.sv
// CHIP-8 RAM owner: font preload, byte-stream program load, then CPU service.
// Define CHIP8_FONT_INIT_EN to include the font preload phase and ROM.
module chip8_mem_responder
  import chip8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  chip8_mem_responder_if.slave  bus,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_err,
  output logic                  cpu_en
);
  logic [7:0]        r_ram [RAM_DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_full;

  logic              w_acc;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;

`ifdef CHIP8_FONT_INIT_EN
  localparam state_t RST_ST = ST_FONT;
  logic [6:0] r_fcnt;
  logic [7:0] w_font;

  chip8_font_rom u_font (
    .i_idx (r_fcnt),
    .o_row (w_font)
  );
`else
  localparam state_t RST_ST = ST_LOAD;
`endif

  // load_ready is only ever high in ST_LOAD
  assign w_acc = load_valid & load_ready;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.mem_write_idx;
    w_wdata = bus.mem_write_byte;
    unique case (1'b1)
`ifdef CHIP8_FONT_INIT_EN
      (r_state == ST_FONT): begin
        w_we    = 1'b1;
        w_waddr = FONT_BASE + ADDR_W'(r_fcnt);
        w_wdata = w_font;
      end
`endif
      w_acc: begin
        w_we    = ~r_full;
        w_waddr = r_ptr;
        w_wdata = load_byte;
      end
      (r_state == ST_RUN): w_we = bus.mem_write;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_ram[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= RST_ST;
      r_ptr             <= LOAD_BASE;
      r_full            <= 1'b0;
      load_ready        <= 1'b0;
      load_err          <= 1'b0;
      cpu_en            <= 1'b0;
      bus.mem_read_ack  <= 1'b0;
      bus.mem_read_byte <= 8'h00;
`ifdef CHIP8_FONT_INIT_EN
      r_fcnt            <= 7'd0;
`endif
    end else begin
      bus.mem_read_ack <= 1'b0;
      unique case (r_state)
        ST_FONT: begin
`ifdef CHIP8_FONT_INIT_EN
          r_fcnt <= r_fcnt + 7'd1;
          if (r_fcnt == 7'(FONT_LEN - 1)) begin
            r_state    <= ST_LOAD;
            load_ready <= 1'b1;
          end
`endif
        end
        ST_LOAD: begin
          load_ready <= 1'b1;
          if (w_acc) begin
            // the last RAM byte is kept; anything after it is dropped
            if (r_full) load_err <= 1'b1;
            else if (r_ptr == {ADDR_W{1'b1}}) r_full <= 1'b1;
            else r_ptr <= r_ptr + 1'b1;
            if (load_last) begin
              r_state    <= ST_RUN;
              load_ready <= 1'b0;
              cpu_en     <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.mem_read) begin
            bus.mem_read_ack  <= 1'b1;
            bus.mem_read_byte <= r_ram[bus.mem_read_idx];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_mem_responder.sv
// Bench for chip8_mem_responder: memory-map model plus directed phases.
// Adapts to the CHIP8_FONT_INIT_EN build option.
module tb_chip8_mem_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_byte = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready, load_err, cpu_en;

  chip8_mem_responder_if bus ();

  chip8_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_err   (load_err),
    .cpu_en     (cpu_en)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] FONT [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90, 8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0, 8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

`ifdef CHIP8_FONT_INIT_EN
  localparam bit HAS_FONT = 1'b1;
`else
  localparam bit HAS_FONT = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  localparam int PH_FONT = 0, PH_LOAD = 1, PH_RUN = 2;
  int ph, fcnt, ptr;
  bit e_ack, e_rdy, e_en, e_err, e_bk;
  logic [7:0] e_byte;
  logic [7:0] mm [4096];
  bit kn [4096];

  function automatic void m_reset();
    ph = HAS_FONT ? PH_FONT : PH_LOAD;
    fcnt = 0; ptr = 'h200;
    e_ack = 0; e_rdy = 0; e_en = 0; e_err = 0;
    e_byte = 8'h00; e_bk = 1;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      e_ack = 0;
      case (ph)
        PH_FONT: begin
          mm[fcnt] = FONT[fcnt]; kn[fcnt] = 1;
          fcnt++;
          if (fcnt == 80) begin ph = PH_LOAD; e_rdy = 1; end
        end
        PH_LOAD: begin
          if (load_valid && e_rdy) begin
            if (ptr < 4096) begin
              mm[ptr] = load_byte; kn[ptr] = 1; ptr++;
            end else e_err = 1;
            if (load_last) begin ph = PH_RUN; e_rdy = 0; e_en = 1; end
          end else e_rdy = 1;
        end
        default: begin
          if (bus.mem_read) begin
            e_ack = 1;
            e_byte = mm[bus.mem_read_idx];
            e_bk = kn[bus.mem_read_idx];
          end
          if (bus.mem_write) begin
            mm[bus.mem_write_idx] = bus.mem_write_byte;
            kn[bus.mem_write_idx] = 1;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_on && rst_n) begin
      chk("ack", bus.mem_read_ack, e_ack);
      chk("load_ready", load_ready, e_rdy);
      chk("cpu_en", cpu_en, e_en);
      chk("load_err", load_err, e_err);
      if (e_bk) chk("rd_byte", bus.mem_read_byte, e_byte);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic idle();
    @(negedge clk);
    load_valid = 0; load_last = 0;
    bus.mem_read = 0; bus.mem_write = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    load_valid = 0; load_last = 0;
    bus.mem_read = 0; bus.mem_write = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_ready(input int exp_lat);
    int n = 0;
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (load_ready) break;
    end
    chk("ready_latency", n, exp_lat);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    @(negedge clk);
    load_valid = 1; load_byte = b; load_last = last;
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.mem_write = 1; bus.mem_write_idx = a; bus.mem_write_byte = d;
    @(negedge clk);
    bus.mem_write = 0;
  endtask

  task automatic cpu_rd(input logic [11:0] a, output logic [7:0] d, output logic ack);
    @(negedge clk);
    bus.mem_read = 1; bus.mem_read_idx = a;
    @(posedge clk); #1;
    d = bus.mem_read_byte; ack = bus.mem_read_ack;
    @(negedge clk);
    bus.mem_read = 0;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  logic [7:0] d;
  logic a;

  initial begin
    bus.mem_read = 0; bus.mem_read_idx = '0;
    bus.mem_write = 0; bus.mem_write_idx = '0; bus.mem_write_byte = '0;
    #2 rst_n = 0;
    m_reset();
    #1;
    chk("rst_ack", bus.mem_read_ack, 0);
    chk("rst_byte", bus.mem_read_byte, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_err", load_err, 0);
    chk("rst_en", cpu_en, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    chk_on = 1;

    // font preload latency and program load
    wait_ready(HAS_FONT ? 80 : 1);
    send(8'h12, 0);
    send(8'h00, 1);
    @(posedge clk); #1;
    chk("post_load_ready", load_ready, 0);
    chk("post_load_en", cpu_en, 1);
    idle();
    if (HAS_FONT) begin
      cpu_rd(12'h000, d, a); chk("font_000", d, 8'hF0);
      cpu_rd(12'h005, d, a); chk("font_005", d, 8'h20);
      cpu_rd(12'h04F, d, a); chk("font_04F", d, 8'h80);
    end

    // single read pulse then back-to-back reads
    cpu_wr(12'h202, 8'h5E);
    cpu_rd(12'h200, d, a);
    chk("rd1_ack", a, 1);
    chk("rd1_byte", d, 8'h12);
    @(posedge clk); #1;
    chk("rd1_ack_drop", bus.mem_read_ack, 0);
    @(negedge clk);
    bus.mem_read = 1; bus.mem_read_idx = 12'h200;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("b2b_ack", bus.mem_read_ack, 1);
      chk("b2b_byte", bus.mem_read_byte, k == 0 ? 8'h12 : (k == 1 ? 8'h00 : 8'h5E));
      @(negedge clk);
      if (k < 2) bus.mem_read_idx = 12'h201 + 12'(k);
      else bus.mem_read = 0;
    end

    // same-cycle read and write to one address
    cpu_wr(12'h300, 8'h00);
    @(negedge clk);
    bus.mem_write = 1; bus.mem_write_idx = 12'h300; bus.mem_write_byte = 8'hAB;
    bus.mem_read = 1; bus.mem_read_idx = 12'h300;
    @(posedge clk); #1;
    chk("rw_old", bus.mem_read_byte, 8'h00);
    idle();
    cpu_rd(12'h300, d, a);
    chk("rw_new", d, 8'hAB);
    cpu_wr(12'h000, 8'h5A);

    // overflow: 3585 bytes from 0x200
    do_reset();
    wait_ready(HAS_FONT ? 80 : 1);
    for (int i = 0; i < 3585; i++) send(pat(i), i == 3584);
    idle();
    chk("ovf_err", load_err, 1);
    chk("ovf_en", cpu_en, 1);
    cpu_rd(12'hFFF, d, a); chk("ovf_fff", d, 8'hFC);
    cpu_rd(12'h200, d, a); chk("ovf_200", d, 8'h03);
    cpu_rd(12'h300, d, a); chk("ovf_300", d, 8'h03);
    cpu_rd(12'h000, d, a); chk("ovf_000", d, HAS_FONT ? 8'hF0 : 8'h5A);

    // reset with ack pending; CPU traffic during load ignored
    do_reset();
    wait_ready(HAS_FONT ? 80 : 1);
    bus.mem_write = 1; bus.mem_write_idx = 12'h300; bus.mem_write_byte = 8'hEE;
    bus.mem_read = 1; bus.mem_read_idx = 12'h300;
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 4);
    idle();
    cpu_rd(12'h300, d, a); chk("ignored_wr", d, 8'h03);
    cpu_rd(12'h204, d, a); chk("load5_204", d, 8'hA4);
    @(negedge clk);
    bus.mem_read = 1; bus.mem_read_idx = 12'h201;
    @(posedge clk); #1;
    chk("pend_ack", bus.mem_read_ack, 1);
    #2 rst_n = 0;
    m_reset();
    #1;
    chk("rst_mid_ack", bus.mem_read_ack, 0);
    chk("rst_mid_en", cpu_en, 0);
    do_reset();
    wait_ready(HAS_FONT ? 80 : 1);
    send(8'hC3, 1);
    idle();
    cpu_rd(12'h200, d, a); chk("reload_200", d, 8'hC3);
    cpu_rd(12'h201, d, a); chk("reload_201", d, 8'hA1);
    idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
